spi_cmd_controller: RTL



---
 rtl/spi_cmd_pkg.sv | 37 +++
 rtl/spi_cmd_controller_if.sv | 28 ++
 rtl/spi_half_tick.sv | 34 +++
 rtl/spi_cmd_controller.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared types and frame layout for the SPI command controller.
// Frame: bit15 R/W (1=write), bits14:8 address, bits7:0 data, MSB first.
package spi_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD,
      GAP
   } state_t;

   localparam int FRAME_W   = 16;
   localparam int RW_BIT    = 15;
   localparam int ADDR_MSB  = 14;
   localparam int ADDR_LSB  = 8;
   localparam int DATA_MSB  = 7;
   localparam int ADDR_W    = ADDR_MSB - ADDR_LSB + 1;
   localparam int DATA_W    = DATA_MSB + 1;
   localparam int BIT_CNT_W = 4;

   localparam logic [BIT_CNT_W-1:0] BIT_LAST = 4'd15;

   function automatic logic [FRAME_W-1:0] pack_frame(
      input logic              w,
      input logic [ADDR_W-1:0] a,
      input logic [DATA_W-1:0] d
   );
      logic [FRAME_W-1:0] f;
      f                     = '0;
      f[RW_BIT]             = w;
      f[ADDR_MSB:ADDR_LSB]  = a;
      f[DATA_MSB:0]         = d;
      return f;
   endfunction

endpackage

// File: rtl/spi_cmd_controller_if.sv
// Request handshake bundle for spi_cmd_controller.
// req_valid/req_write/req_addr/req_data: master -> slave; req_ready: slave -> master.
interface spi_cmd_controller_if;
   import spi_cmd_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_data;

   modport master (
      output req_valid,
      output req_write,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_write,
      input  req_addr,
      input  req_data,
      output req_ready
   );

endinterface

// File: rtl/spi_half_tick.sv
// SCLK half-period timer: one-cycle tick at the end of every CLK_DIV cycles.
// Ports: clk, rst (sync, active-high), clr (sync hold at zero), tick (out).
module spi_half_tick #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      tick  = !clr && (cnt_q == LAST);
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_cmd_controller.sv
// Mode-0 SPI master sending one 16-bit command frame per accepted request.
// Ports: clk, rst (sync, active-high), req (handshake if, slave side),
//   sclk/ncs/copi (SPI pins), busy (accept..GAP end), done (pulse at nCS rise).
// Option SPI_CMD_READBACK_EN: adds cipo (in) and rsp_data (out, 8) captured
//   from the last 8 rising edges of read frames.
module spi_cmd_controller
   import spi_cmd_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int CS_GAP  = 4
) (
   input  logic clk,
   input  logic rst,
   spi_cmd_controller_if.slave req,
   output logic sclk,
   output logic ncs,
   output logic copi,
   output logic busy,
   output logic done
`ifdef SPI_CMD_READBACK_EN
   ,
   input  logic              cipo,
   output logic [DATA_W-1:0] rsp_data
`endif
);

   localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

   state_t               state_q, state_d;
   logic [FRAME_W-1:0]   sr_q, sr_d;
   logic [BIT_CNT_W-1:0] bit_q, bit_d;
   logic                 ph_q, ph_d;
   logic [GW-1:0]        gap_q, gap_d;
   logic                 sclk_q, sclk_d;
   logic                 ncs_q, ncs_d;
   logic                 copi_q, copi_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 ready;
   logic                 accept;
   logic                 in_frame;
   logic                 tick;
   logic                 tick_clr;

   assign ready         = (state_q == IDLE) && !rst;
   assign req.req_ready = ready;
   assign accept        = req.req_valid && ready;
   assign tick_clr      = (state_q == IDLE) || (state_q == GAP);

   spi_half_tick #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .clr (tick_clr),
      .tick(tick)
   );

   // ph_q: 0 = sclk high half of a bit, 1 = low half.
   // The shift register advances on the high->low tick, so copi
   // changes on sclk falling edges and is stable at each rise.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bit_d   = bit_q;
      ph_d    = ph_q;
      gap_d   = gap_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               sr_d    = pack_frame(req.req_write, req.req_addr,
                                    req.req_data);
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               state_d = SHIFT;
               ph_d    = 1'b0;
               bit_d   = '0;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!ph_q) begin
                  ph_d = 1'b1;
                  sr_d = {sr_q[FRAME_W-2:0], 1'b0};
               end else if (bit_q == BIT_LAST) begin
                  state_d = HOLD;
               end else begin
                  ph_d  = 1'b0;
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (tick) begin
               state_d = GAP;
               gap_d   = '0;
               done_d  = 1'b1;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Pin values are registered from the next state so they change
      // exactly with the state and never glitch.
      in_frame = state_d inside {SETUP, SHIFT, HOLD};
      ncs_d    = !in_frame;
      sclk_d   = (state_d == SHIFT) && !ph_d;
      copi_d   = in_frame && sr_d[FRAME_W-1];
      busy_d   = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         bit_q   <= '0;
         ph_q    <= 1'b0;
         gap_q   <= '0;
         sclk_q  <= 1'b0;
         ncs_q   <= 1'b1;
         copi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         bit_q   <= bit_d;
         ph_q    <= ph_d;
         gap_q   <= gap_d;
         sclk_q  <= sclk_d;
         ncs_q   <= ncs_d;
         copi_q  <= copi_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sclk = sclk_q;
   assign ncs  = ncs_q;
   assign copi = copi_q;
   assign busy = busy_q;
   assign done = done_q;

`ifdef SPI_CMD_READBACK_EN
   logic              rd_q, rd_d;
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] rsp_q, rsp_d;

   // Sample cipo on the clk edge where sclk rises, for bits 8..15.
   always_comb begin
      rd_d  = rd_q;
      rx_d  = rx_q;
      rsp_d = rsp_q;
      if (accept) begin
         rd_d = !req.req_write;
      end
      if (sclk_d && !sclk_q && bit_d[BIT_CNT_W-1]) begin
         rx_d = {rx_q[DATA_W-2:0], cipo};
      end
      if (done_d && rd_q) begin
         rsp_d = rx_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q  <= 1'b0;
         rx_q  <= '0;
         rsp_q <= '0;
      end else begin
         rd_q  <= rd_d;
         rx_q  <= rx_d;
         rsp_q <= rsp_d;
      end
   end

   assign rsp_data = rsp_q;
`endif

endmodule
